// File: rtl/vespa_pkg.sv
// Shared VeSPA decode definitions: opcodes, instruction field positions, register-file geometry.
package vespa_pkg;

    localparam int NREGS   = 32;
    localparam int REG_MSB = 4;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 27;
    localparam int RD_HI   = 26;
    localparam int RD_LO   = 22;
    localparam int CD_HI   = 26;
    localparam int CD_LO   = 23;
    localparam int RS1_HI  = 21;
    localparam int RS1_LO  = 17;
    localparam int IMM_BIT = 16;
    localparam int RS2_HI  = 15;
    localparam int RS2_LO  = 11;

    typedef enum logic [4:0] {
        OP_NOP = 5'd0,
        OP_ADD = 5'd1,
        OP_SUB = 5'd2,
        OP_OR  = 5'd3,
        OP_AND = 5'd4,
        OP_NOT = 5'd5,
        OP_XOR = 5'd6,
        OP_CMP = 5'd7,
        OP_BXX = 5'd8,
        OP_JMP = 5'd9,
        OP_LD  = 5'd10,
        OP_LDI = 5'd11,
        OP_LDX = 5'd12,
        OP_ST  = 5'd13,
        OP_STX = 5'd14,
        OP_HLT = 5'd31
    } opcode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } dec_state_e;

endpackage

// File: rtl/vespa_regfile.sv
// VeSPA register file: two combinational read ports with writeback bypass, one synchronous write port.
module vespa_regfile
    import vespa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [AW-1:0]     rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Write-through: a value being written this cycle is visible to readers in the same cycle.
    assign rd1_data = (wb_en && (wb_addr == rd1_addr)) ? wb_data : regs[rd1_addr];
    assign rd2_data = (wb_en && (wb_addr == rd2_addr)) ? wb_data : regs[rd2_addr];

endmodule

// File: rtl/vespa_decode.sv
// VeSPA decode stage: field decode, register read, load-use interlock, HLT state and the ID/EX register.
module vespa_decode
    import vespa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              i_clk_d,
    input  logic              i_rst_d,
    input  logic              i_valid_d,
    output logic              o_ready_d,
    input  logic [31:0]       i_PC_d,
    input  logic [31:0]       i_IR_d,
    input  logic              i_flush_d,
    input  logic              i_wb_en,
    input  logic [REG_MSB:0]  i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_valid_x,
    input  logic              i_ready_x,
    output logic [31:0]       o_PC_x,
    output logic [4:0]        o_op_x,
    output logic [REG_MSB:0]  o_rdst_x,
    output logic [3:0]        o_cond_x,
    output logic [DATA_W-1:0] o_rs1_val_x,
    output logic [DATA_W-1:0] o_rs2_val_x,
    output logic [DATA_W-1:0] o_imm_x,
    output logic              o_use_imm_x,
    output logic              o_wen_x,
    output logic              o_mem_rd_x,
    output logic              o_mem_wr_x,
    output logic              o_halted
);

    function automatic logic signed [DATA_W-1:0] sext(input logic [31:0] raw, input int w);
        logic signed [31:0] t;
        t = $signed(raw << (32 - w));
        return DATA_W'(t >>> (32 - w));
    endfunction

    dec_state_e              state;
    opcode_e                 op_p0;
    logic [REG_MSB:0]        rdst_p0;
    logic [REG_MSB:0]        rs1_addr_p0;
    logic [REG_MSB:0]        rs2_field_p0;
    logic [REG_MSB:0]        rs2_addr_p0;
    logic [DATA_W-1:0]       rs1_val_p0;
    logic [DATA_W-1:0]       rs2_val_p0;
    logic signed [DATA_W-1:0] imm_p0;
    logic                    use_imm_p0;
    logic                    wen_p0;
    logic                    mem_rd_p0;
    logic                    mem_wr_p0;
    logic                    store_p0;
    logic                    load_use_p0;
    logic                    load_en;
    logic                    accept;

    assign rdst_p0      = i_IR_d[RD_HI:RD_LO];
    assign rs1_addr_p0  = i_IR_d[RS1_HI:RS1_LO];
    assign rs2_field_p0 = i_IR_d[RS2_HI:RS2_LO];
    assign rs2_addr_p0  = store_p0 ? rdst_p0 : rs2_field_p0;

    always_comb begin
        op_p0      = opcode_e'(i_IR_d[OP_HI:OP_LO]);
        imm_p0     = '0;
        use_imm_p0 = 1'b0;
        wen_p0     = 1'b0;
        mem_rd_p0  = 1'b0;
        mem_wr_p0  = 1'b0;
        store_p0   = 1'b0;
        case (opcode_e'(i_IR_d[OP_HI:OP_LO]))
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_NOT, OP_XOR, OP_CMP: begin
                wen_p0 = (i_IR_d[OP_HI:OP_LO] != OP_CMP);
                if (i_IR_d[IMM_BIT]) begin
                    use_imm_p0 = 1'b1;
                    imm_p0     = sext(i_IR_d, 16);
                end
            end
            OP_BXX: begin
                use_imm_p0 = 1'b1;
                imm_p0     = sext(i_IR_d, 23);
            end
            OP_JMP: begin
                use_imm_p0 = 1'b1;
                imm_p0     = sext(i_IR_d, 16);
                wen_p0     = i_IR_d[IMM_BIT];
            end
            OP_LD, OP_LDI: begin
                use_imm_p0 = 1'b1;
                imm_p0     = sext(i_IR_d, 22);
                wen_p0     = 1'b1;
                mem_rd_p0  = (i_IR_d[OP_HI:OP_LO] == OP_LD);
            end
            OP_LDX: begin
                use_imm_p0 = 1'b1;
                imm_p0     = sext(i_IR_d, 17);
                wen_p0     = 1'b1;
                mem_rd_p0  = 1'b1;
            end
            OP_ST: begin
                use_imm_p0 = 1'b1;
                imm_p0     = sext(i_IR_d, 22);
                mem_wr_p0  = 1'b1;
                store_p0   = 1'b1;
            end
            OP_STX: begin
                use_imm_p0 = 1'b1;
                imm_p0     = sext(i_IR_d, 17);
                mem_wr_p0  = 1'b1;
                store_p0   = 1'b1;
            end
            OP_NOP, OP_HLT: ;
            default: op_p0 = OP_NOP;
        endcase
    end

    vespa_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (i_clk_d),
        .rst_n    (i_rst_d),
        .rd1_addr (rs1_addr_p0),
        .rd1_data (rs1_val_p0),
        .rd2_addr (rs2_addr_p0),
        .rd2_data (rs2_val_p0),
        .wb_en    (i_wb_en),
        .wb_addr  (i_wb_addr),
        .wb_data  (i_wb_data)
    );

    // A load sitting in ID/EX cannot forward; any reader of its destination waits one slot.
    assign load_use_p0 = o_valid_x && o_mem_rd_x &&
                         ((rs1_addr_p0 == o_rdst_x) ||
                          (store_p0 ? (rdst_p0 == o_rdst_x)
                                    : (!i_IR_d[IMM_BIT] && (rs2_field_p0 == o_rdst_x))));

    assign load_en   = !o_valid_x || i_ready_x;
    assign o_ready_d = i_flush_d || (load_en && !load_use_p0 && (state == ST_RUN));
    assign accept    = i_valid_d && o_ready_d && !i_flush_d;

    // ID/EX boundary
    always_ff @(posedge i_clk_d or negedge i_rst_d) begin
        if (!i_rst_d) begin
            o_valid_x   <= 1'b0;
            o_PC_x      <= '0;
            o_op_x      <= '0;
            o_rdst_x    <= '0;
            o_cond_x    <= '0;
            o_rs1_val_x <= '0;
            o_rs2_val_x <= '0;
            o_imm_x     <= '0;
            o_use_imm_x <= 1'b0;
            o_wen_x     <= 1'b0;
            o_mem_rd_x  <= 1'b0;
            o_mem_wr_x  <= 1'b0;
        end else if (i_flush_d) begin
            o_valid_x <= 1'b0;
        end else if (load_en) begin
            o_valid_x <= accept;
            if (accept) begin
                o_PC_x      <= i_PC_d;
                o_op_x      <= op_p0;
                o_rdst_x    <= rdst_p0;
                o_cond_x    <= i_IR_d[CD_HI:CD_LO];
                o_rs1_val_x <= rs1_val_p0;
                o_rs2_val_x <= rs2_val_p0;
                o_imm_x     <= imm_p0;
                o_use_imm_x <= use_imm_p0;
                o_wen_x     <= wen_p0;
                o_mem_rd_x  <= mem_rd_p0;
                o_mem_wr_x  <= mem_wr_p0;
            end
        end
    end

    always_ff @(posedge i_clk_d or negedge i_rst_d) begin
        if (!i_rst_d) begin
            state    <= ST_RUN;
            o_halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && (op_p0 == OP_HLT)) begin
                        state    <= ST_HALTED;
                        o_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    // The HLT was fetched down a mispredicted path; redirect resumes execution.
                    if (i_flush_d) begin
                        state    <= ST_RUN;
                        o_halted <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    o_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vespa_decode.sv
// Directed bench for vespa_decode: field decode, bypass, load-use bubble, back-pressure, HLT/flush, async reset.
module tb_vespa_decode;

    logic        i_clk_d = 1'b0;
    logic        i_rst_d;
    logic        i_valid_d;
    logic        o_ready_d;
    logic [31:0] i_PC_d;
    logic [31:0] i_IR_d;
    logic        i_flush_d;
    logic        i_wb_en;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_valid_x;
    logic        i_ready_x;
    logic [31:0] o_PC_x;
    logic [4:0]  o_op_x;
    logic [4:0]  o_rdst_x;
    logic [3:0]  o_cond_x;
    logic [31:0] o_rs1_val_x;
    logic [31:0] o_rs2_val_x;
    logic [31:0] o_imm_x;
    logic        o_use_imm_x;
    logic        o_wen_x;
    logic        o_mem_rd_x;
    logic        o_mem_wr_x;
    logic        o_halted;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 i_clk_d = ~i_clk_d;

    vespa_decode #(
        .DATA_W (32),
        .NREGS  (32)
    ) dut (
        .i_clk_d     (i_clk_d),
        .i_rst_d     (i_rst_d),
        .i_valid_d   (i_valid_d),
        .o_ready_d   (o_ready_d),
        .i_PC_d      (i_PC_d),
        .i_IR_d      (i_IR_d),
        .i_flush_d   (i_flush_d),
        .i_wb_en     (i_wb_en),
        .i_wb_addr   (i_wb_addr),
        .i_wb_data   (i_wb_data),
        .o_valid_x   (o_valid_x),
        .i_ready_x   (i_ready_x),
        .o_PC_x      (o_PC_x),
        .o_op_x      (o_op_x),
        .o_rdst_x    (o_rdst_x),
        .o_cond_x    (o_cond_x),
        .o_rs1_val_x (o_rs1_val_x),
        .o_rs2_val_x (o_rs2_val_x),
        .o_imm_x     (o_imm_x),
        .o_use_imm_x (o_use_imm_x),
        .o_wen_x     (o_wen_x),
        .o_mem_rd_x  (o_mem_rd_x),
        .o_mem_wr_x  (o_mem_wr_x),
        .o_halted    (o_halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk_d);
        #1;
    endtask

    task automatic present(input logic [31:0] ir, input logic [31:0] pc);
        i_valid_d = 1'b1;
        i_IR_d    = ir;
        i_PC_d    = pc;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        i_wb_en   = 1'b1;
        i_wb_addr = addr;
        i_wb_data = data;
        tick();
        i_wb_en   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
        present(ir, pc);
        tick();
        i_valid_d = 1'b0;
    endtask

    initial begin
        i_rst_d   = 1'b0;
        i_valid_d = 1'b0;
        i_PC_d    = '0;
        i_IR_d    = '0;
        i_flush_d = 1'b0;
        i_wb_en   = 1'b0;
        i_wb_addr = '0;
        i_wb_data = '0;
        i_ready_x = 1'b1;
        #12;
        chk("rst_valid", 32'(o_valid_x), 32'd0);
        chk("rst_halted", 32'(o_halted), 32'd0);
        chk("rst_imm", o_imm_x, 32'd0);
        chk("rst_ready", 32'(o_ready_d), 32'd1);
        i_rst_d = 1'b1;
        tick();

        wb_write(5'd1, 32'd7);
        wb_write(5'd5, 32'h55);

        // ADD r3,r1,#-2
        present(32'h08C3FFFE, 32'h100);
        #1 chk("add_ready", 32'(o_ready_d), 32'd1);
        tick();
        i_valid_d = 1'b0;
        chk("add_valid", 32'(o_valid_x), 32'd1);
        chk("add_op", 32'(o_op_x), 32'd1);
        chk("add_rdst", 32'(o_rdst_x), 32'd3);
        chk("add_rs1", o_rs1_val_x, 32'd7);
        chk("add_imm", o_imm_x, 32'hFFFFFFFE);
        chk("add_useimm", 32'(o_use_imm_x), 32'd1);
        chk("add_wen", 32'(o_wen_x), 32'd1);
        chk("add_pc", o_PC_x, 32'h100);

        // SUB r4,r2,r2 with r2=0xDEAD written back in the same cycle
        present(32'h11041000, 32'h104);
        i_wb_en   = 1'b1;
        i_wb_addr = 5'd2;
        i_wb_data = 32'hDEAD;
        tick();
        i_valid_d = 1'b0;
        i_wb_en   = 1'b0;
        chk("byp_op", 32'(o_op_x), 32'd2);
        chk("byp_rs1", o_rs1_val_x, 32'hDEAD);
        chk("byp_rs2", o_rs2_val_x, 32'hDEAD);
        chk("byp_useimm", 32'(o_use_imm_x), 32'd0);

        // ST r5,#-1: store source comes from rdst
        issue(32'h697FFFFF, 32'h108);
        chk("st_imm", o_imm_x, 32'hFFFFFFFF);
        chk("st_memwr", 32'(o_mem_wr_x), 32'd1);
        chk("st_wen", 32'(o_wen_x), 32'd0);
        chk("st_rs2", o_rs2_val_x, 32'h55);

        // BXX cond=5, most negative 23-bit offset
        issue(32'h42C00000, 32'h10C);
        chk("bxx_cond", 32'(o_cond_x), 32'd5);
        chk("bxx_imm", o_imm_x, 32'hFFC00000);
        chk("bxx_wen", 32'(o_wen_x), 32'd0);

        // JMP with link into r31
        issue(32'h4FC18000, 32'h110);
        chk("jmp_imm", o_imm_x, 32'hFFFF8000);
        chk("jmp_wen", 32'(o_wen_x), 32'd1);
        chk("jmp_rdst", 32'(o_rdst_x), 32'd31);

        // LD r6 then ADD r7,r6,r6: one bubble
        present(32'h51800000, 32'h114);
        tick();
        chk("ld_memrd", 32'(o_mem_rd_x), 32'd1);
        present(32'h09CC3000, 32'h118);
        #1 chk("lu_ready", 32'(o_ready_d), 32'd0);
        tick();
        chk("lu_bubble", 32'(o_valid_x), 32'd0);
        chk("lu_ready2", 32'(o_ready_d), 32'd1);
        tick();
        i_valid_d = 1'b0;
        chk("lu_add_valid", 32'(o_valid_x), 32'd1);
        chk("lu_add_rdst", 32'(o_rdst_x), 32'd7);

        // LD r6 then ADD r7,r1,r2: no dependency
        present(32'h51800000, 32'h11C);
        tick();
        present(32'h09C21000, 32'h120);
        #1 chk("nolu_ready", 32'(o_ready_d), 32'd1);
        tick();
        i_valid_d = 1'b0;
        chk("nolu_valid", 32'(o_valid_x), 32'd1);
        chk("nolu_rs1", o_rs1_val_x, 32'd7);

        // Back-pressure: OR r8,r1,#5 held three cycles, XOR r9,r1,r1 waiting
        issue(32'h1A030005, 32'h124);
        i_ready_x = 1'b0;
        present(32'h32420800, 32'h128);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", 32'(o_valid_x), 32'd1);
            chk("stall_op", 32'(o_op_x), 32'd3);
            chk("stall_imm", o_imm_x, 32'd5);
            chk("stall_ready", 32'(o_ready_d), 32'd0);
            tick();
        end
        i_ready_x = 1'b1;
        #1 chk("rel_ready", 32'(o_ready_d), 32'd1);
        tick();
        i_valid_d = 1'b0;
        chk("rel_op", 32'(o_op_x), 32'd6);
        chk("rel_rdst", 32'(o_rdst_x), 32'd9);
        chk("rel_rs2", o_rs2_val_x, 32'd7);

        // HLT, drain, then flush back to RUN
        present(32'hF8000000, 32'h12C);
        tick();
        present(32'h00000000, 32'h130);
        #1;
        chk("hlt_halted", 32'(o_halted), 32'd1);
        chk("hlt_op", 32'(o_op_x), 32'd31);
        chk("hlt_ready", 32'(o_ready_d), 32'd0);
        tick();
        chk("hlt_drain", 32'(o_valid_x), 32'd0);
        chk("hlt_ready2", 32'(o_ready_d), 32'd0);
        i_flush_d = 1'b1;
        #1 chk("flush_ready", 32'(o_ready_d), 32'd1);
        tick();
        i_flush_d = 1'b0;
        chk("flush_halted", 32'(o_halted), 32'd0);
        chk("flush_valid", 32'(o_valid_x), 32'd0);
        present(32'h08C3FFFE, 32'h200);
        #1 chk("resume_ready", 32'(o_ready_d), 32'd1);
        tick();
        i_valid_d = 1'b0;
        chk("resume_valid", 32'(o_valid_x), 32'd1);
        chk("resume_pc", o_PC_x, 32'h200);

        // Asynchronous reset mid-run
        #2 i_rst_d = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid_x), 32'd0);
        chk("arst_op", 32'(o_op_x), 32'd0);
        chk("arst_imm", o_imm_x, 32'd0);
        chk("arst_halted", 32'(o_halted), 32'd0);
        tick();
        i_rst_d = 1'b1;
        tick();
        issue(32'h080A2800, 32'h300);
        chk("arst_r5_rs1", o_rs1_val_x, 32'd0);
        chk("arst_r5_rs2", o_rs2_val_x, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
